// File: rtl/x_uart_tx_fifo_if.sv
// Handshake bundle between the byte producer, the TX FIFO and x_uart_tx.
// The slave modport is the FIFO's view. The master modport is the view of
// whatever drives the producer side and the UART accept.
interface x_uart_tx_fifo_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_accept;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_accept;
    logic             o_full;
    logic             o_empty;

    modport slave (
        input  i_data, i_valid, i_accept,
        output o_accept, o_data, o_valid, o_full, o_empty
    );

    modport master (
        output i_data, i_valid, i_accept,
        input  o_accept, o_data, o_valid, o_full, o_empty
    );
endinterface

// File: rtl/x_uart_tx_fifo.sv
// x_uart_tx_fifo: byte FIFO that buffers producer bursts in front of x_uart_tx.
// The pointers are log2(DEPTH)+1 bits wide. The extra MSB tells full apart from
// empty. Flags are registered from the next-state pointers, so no input
// reaches an output combinationally. There is no fall-through: a byte pushed
// into an empty FIFO becomes visible on the cycle after the push.
// Optional feature: define X_UART_TX_FIFO_COUNT_EN to add the registered
// occupancy output o_count. With the macro undefined, the port is absent.
module x_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
`ifdef X_UART_TX_FIFO_COUNT_EN
    output logic [$clog2(DEPTH):0] o_count,
`endif
    x_uart_tx_fifo_if.slave       bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic             full_q;
    logic             full_d;
    logic             empty_q;
    logic             empty_d;
    logic             push_s;
    logic             pop_s;

    // Qualify the handshakes against the registered flags, then derive the next pointers and flags.
    always_comb begin
        push_s   = bus.i_valid & ~full_q;
        pop_s    = bus.i_accept & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers. Reset drops every queued byte and ignores same-cycle handshakes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write. The contents are never reset, and a write is suppressed while reset is low.
    always_ff @(posedge i_clk) begin
        if (push_s && i_rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.i_data;
        end
    end

`ifdef X_UART_TX_FIFO_COUNT_EN
    logic [PW-1:0] count_q;

    // Occupancy register. It is updated on the same edge as the flags, so its timing matches theirs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            count_q <= {PW{1'b0}};
        end else begin
            count_q <= wr_ptr_d - rd_ptr_d;
        end
    end

    assign o_count = count_q;
`endif

    assign bus.o_accept = ~full_q;
    assign bus.o_valid  = ~empty_q;
    assign bus.o_full   = full_q;
    assign bus.o_empty  = empty_q;
    assign bus.o_data   = mem_q[rd_ptr_q[AW-1:0]];

endmodule
